// File: rtl/dot_product_acc_if.sv
// dot_product_acc_if
//   Bundles the operand handshake, the multiplier issue/return path and the
//   result port of dot_product_acc.
//   slave  : the dot_product_acc side (takes operands and products, drives results).
//   master : the environment side (operand source, multiplier_16, result consumer).
//   Signals:
//     I_VLD / O_RDY / I_A / I_B       operand pair handshake, Q3.13 operands
//     O_MUL_VLD / O_MUL_M1 / O_MUL_M2 issue to multiplier I_VLD / I_M1 / I_M2
//     I_MUL_BUSY / I_MUL_VLD          from multiplier O_MUL_BUSY / O_VLD
//     I_MUL_PRODUCT                   from multiplier O_PRODUCT, Q3.13
//     O_VLD / O_DOT / O_OVF           one-cycle result pulse, dot product, saturation flag
interface dot_product_acc_if;
    logic        I_VLD;
    logic        O_RDY;
    logic [15:0] I_A;
    logic [15:0] I_B;
    logic        O_MUL_VLD;
    logic [15:0] O_MUL_M1;
    logic [15:0] O_MUL_M2;
    logic        I_MUL_BUSY;
    logic        I_MUL_VLD;
    logic [15:0] I_MUL_PRODUCT;
    logic        O_VLD;
    logic [15:0] O_DOT;
    logic        O_OVF;

    modport slave (
        input  I_VLD, I_A, I_B, I_MUL_BUSY, I_MUL_VLD, I_MUL_PRODUCT,
        output O_RDY, O_MUL_VLD, O_MUL_M1, O_MUL_M2, O_VLD, O_DOT, O_OVF
    );

    modport master (
        output I_VLD, I_A, I_B, I_MUL_BUSY, I_MUL_VLD, I_MUL_PRODUCT,
        input  O_RDY, O_MUL_VLD, O_MUL_M1, O_MUL_M2, O_VLD, O_DOT, O_OVF
    );
endinterface

// File: rtl/dot_product_acc.sv
// dot_product_acc
//   Streaming Q3.13 dot-product engine. Buffers one operand pair, issues it to an
//   external multiplier, accumulates returned products in an ACC_W-bit accumulator
//   and emits one 16-bit dot product per VEC_LEN pairs.
//   Parameters:
//     VEC_LEN : elements per dot product (>= 2)
//     ACC_W   : accumulator width (>= 16 + clog2(VEC_LEN))
//   Ports:
//     I_CLK   : clock
//     I_RST_N : synchronous active-low reset
//     bus     : dot_product_acc_if.slave (operand handshake, multiplier path, result)
//   Build option:
//     DOT_SAT_EN defined   -> O_DOT saturates to 0x7FFF / 0x8000, O_OVF flags a clamp.
//     DOT_SAT_EN undefined -> O_DOT = acc[15:0] (wraps), O_OVF held at 0.
module dot_product_acc #(
    parameter int unsigned VEC_LEN = 64,
    parameter int unsigned ACC_W   = 24
) (
    input logic              I_CLK,
    input logic              I_RST_N,
    dot_product_acc_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN);

`ifdef DOT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);
`endif

    logic [15:0]             a_q;
    logic [15:0]             b_q;
    logic                    op_vld_q;
    logic                    inflight_q;
    logic                    out_pend_q;
    logic [CNT_W-1:0]        issue_cnt_q;
    logic [CNT_W-1:0]        acc_cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    vld_q;
    logic [15:0]             dot_q;
    logic                    ovf_q;

    logic                    rdy;
    logic                    accept;
    logic                    issue;
    logic                    accum;
    logic signed [ACC_W-1:0] prod_ext;
    logic [15:0]             dot_d;
    logic                    ovf_d;

    // Stop taking pairs once a full vector has been issued so the next vector
    // never mixes into the current sum.
    assign rdy    = !op_vld_q && (issue_cnt_q < LAST_CNT) && !out_pend_q;
    assign accept = bus.I_VLD && rdy;
    assign issue  = op_vld_q && !inflight_q && !bus.I_MUL_BUSY;
    // A product with nothing in flight is stale (e.g. issued before a reset).
    assign accum  = bus.I_MUL_VLD && inflight_q;

    assign prod_ext = {{(ACC_W-16){bus.I_MUL_PRODUCT[15]}}, bus.I_MUL_PRODUCT};

    assign bus.O_RDY     = rdy;
    assign bus.O_MUL_VLD = issue;
    assign bus.O_MUL_M1  = a_q;
    assign bus.O_MUL_M2  = b_q;
    assign bus.O_VLD     = vld_q;
    assign bus.O_DOT     = dot_q;
    assign bus.O_OVF     = ovf_q;

    // Products and sum share the Q3.13 scale, so the result is a plain slice
    // (or a clamp when saturation is built in).
    always_comb begin
        dot_d = acc_q[15:0];
        ovf_d = 1'b0;
`ifdef DOT_SAT_EN
        if (acc_q > SAT_MAX) begin
            dot_d = 16'h7FFF;
            ovf_d = 1'b1;
        end else if (acc_q < SAT_MIN) begin
            dot_d = 16'h8000;
            ovf_d = 1'b1;
        end
`endif
    end

    // accept/issue are exclusive (op_vld), issue/accum are exclusive (inflight),
    // and nothing else can happen while out_pend is set.
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            a_q         <= '0;
            b_q         <= '0;
            op_vld_q    <= 1'b0;
            inflight_q  <= 1'b0;
            out_pend_q  <= 1'b0;
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
            acc_q       <= '0;
            vld_q       <= 1'b0;
            dot_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (accept) begin
                a_q      <= bus.I_A;
                b_q      <= bus.I_B;
                op_vld_q <= 1'b1;
            end
            if (issue) begin
                op_vld_q    <= 1'b0;
                inflight_q  <= 1'b1;
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            if (accum) begin
                acc_q      <= acc_q + prod_ext;
                inflight_q <= 1'b0;
                acc_cnt_q  <= acc_cnt_q + 1'b1;
            end
            if (out_pend_q) begin
                vld_q       <= 1'b1;
                dot_q       <= dot_d;
                ovf_q       <= ovf_d;
                acc_q       <= '0;
                issue_cnt_q <= '0;
                acc_cnt_q   <= '0;
                out_pend_q  <= 1'b0;
            end else if (acc_cnt_q == LAST_CNT) begin
                out_pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_acc.sv
`timescale 1ns/1ps
module tb_dot_product_acc;
    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned ACC_W   = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dot_product_acc_if bus();

    dot_product_acc #(.VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) dut (
        .I_CLK   (clk),
        .I_RST_N (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endfunction

    // Q3.13 x Q3.13 -> Q3.13 (arithmetic shift, truncate)
    function automatic logic [15:0] q_mul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p[28:13];
    endfunction

    // ---------------- multiplier model (variable latency) ----------------
    logic        mul_busy = 1'b0;
    logic        mul_vld  = 1'b0;
    logic [15:0] mul_prod = 16'h0;
    logic [15:0] mul_res  = 16'h0;
    int          mul_left = 0;
    logic        stray    = 1'b0;

    always @(posedge clk) begin
        mul_vld <= 1'b0;
        if (mul_busy) begin
            if (mul_left <= 1) begin
                mul_busy <= 1'b0;
                mul_vld  <= 1'b1;
                mul_prod <= mul_res;
            end else begin
                mul_left <= mul_left - 1;
            end
        end else if (bus.O_MUL_VLD) begin
            mul_busy <= 1'b1;
            mul_left <= int'($urandom_range(1, 4));
            mul_res  <= q_mul(bus.O_MUL_M1, bus.O_MUL_M2);
        end
    end

    assign bus.I_MUL_BUSY    = mul_busy;
    assign bus.I_MUL_VLD     = mul_vld | stray;
    assign bus.I_MUL_PRODUCT = stray ? 16'h7FFF : mul_prod;

    // ---------------- reference model ----------------
    logic [15:0] exp_dot_q[$];
    logic        exp_ovf_q[$];
    int          cur_sum = 0;
    int          cur_n = 0;
    int          hs_cnt = 0;
    int          mul_vld_cnt = 0;

    function automatic void result_of(input int s, output logic [15:0] d, output logic o);
`ifdef DOT_SAT_EN
        if (s > 32767) begin
            d = 16'h7FFF; o = 1'b1;
        end else if (s < -32768) begin
            d = 16'h8000; o = 1'b1;
        end else begin
            d = s[15:0]; o = 1'b0;
        end
`else
        d = s[15:0];
        o = 1'b0;
`endif
    endfunction

    initial begin : model
        logic [15:0] d;
        logic        o;
        forever begin
            @(posedge clk);
            if (bus.I_MUL_VLD) mul_vld_cnt++;
            if (!rst_n) begin
                cur_sum = 0;
                cur_n = 0;
                exp_dot_q.delete();
                exp_ovf_q.delete();
            end else if (bus.I_VLD && bus.O_RDY) begin
                hs_cnt++;
                cur_sum += int'($signed(q_mul(bus.I_A, bus.I_B)));
                cur_n++;
                if (cur_n == VEC_LEN) begin
                    result_of(cur_sum, d, o);
                    exp_dot_q.push_back(d);
                    exp_ovf_q.push_back(o);
                    cur_sum = 0;
                    cur_n = 0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    bit          chk_en = 1'b0;
    int          vld_cnt = 0;
    logic [15:0] held_dot = 16'h0;
    logic [15:0] got_dot[$];
    logic        got_ovf[$];

    initial begin : compare
        logic [15:0] ed;
        logic        eo;
        forever begin
            @(posedge clk);
            #2;
            if (!chk_en) continue;
            if (!rst_n) begin
                held_dot = 16'h0;
                continue;
            end
            check("mul_vld_while_busy", {31'd0, bus.O_MUL_VLD & bus.I_MUL_BUSY}, 32'd0);
            if (bus.O_VLD) begin
                vld_cnt++;
                got_dot.push_back(bus.O_DOT);
                got_ovf.push_back(bus.O_OVF);
                if (exp_dot_q.size() == 0) begin
                    note_fail("unexpected_o_vld");
                end else begin
                    ed = exp_dot_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    check("o_dot", {16'd0, bus.O_DOT}, {16'd0, ed});
                    check("o_ovf", {31'd0, bus.O_OVF}, {31'd0, eo});
                    held_dot = ed;
                end
            end else begin
                check("o_dot_hold", {16'd0, bus.O_DOT}, {16'd0, held_dot});
            end
        end
    end

    // ---------------- stimulus ----------------
    bit abort = 1'b0;

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input bit garble);
        int n;
        bit rdy;
        bit v;
        n = 0;
        forever begin
            if (abort) break;
            v = garble ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.I_VLD = v;
            bus.I_A   = v ? a : 16'($urandom);
            bus.I_B   = v ? b : 16'($urandom);
            rdy = bus.O_RDY;
            @(negedge clk);
            if (rdy && v) break;
            n++;
            if (n >= 2000) begin
                note_fail("send_timeout");
                break;
            end
        end
        bus.I_VLD = 1'b0;
    endtask

    task automatic send_vec(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < VEC_LEN; i++) send_pair(a, b, 1'b0);
    endtask

    task automatic wait_vld(input int target, input string name);
        int n;
        n = 0;
        while (vld_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (vld_cnt < target) note_fail(name);
        repeat (10) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int hbase;
        int mbase;
        int n;
        bus.I_VLD = 1'b0;
        bus.I_A   = 16'h0;
        bus.I_B   = 16'h0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mul_vld", {31'd0, bus.O_MUL_VLD}, 32'd0);
        check("rst_mul_m1", {16'd0, bus.O_MUL_M1}, 32'd0);
        check("rst_mul_m2", {16'd0, bus.O_MUL_M2}, 32'd0);
        check("rst_o_vld", {31'd0, bus.O_VLD}, 32'd0);
        check("rst_o_dot", {16'd0, bus.O_DOT}, 32'd0);
        check("rst_o_ovf", {31'd0, bus.O_OVF}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_reset", {31'd0, bus.O_RDY}, 32'd1);
        chk_en = 1'b1;

        // 0.5 x 0.5, four times -> 1.0
        base = vld_cnt;
        send_vec(16'h1000, 16'h1000);
        wait_vld(base + 1, "s1_timeout");
        check("s1_count", vld_cnt - base, 1);
        check("s1_dot", {16'd0, got_dot[got_dot.size()-1]}, 32'h2000);
        check("s1_ovf", {31'd0, got_ovf[got_ovf.size()-1]}, 32'd0);

        // 1.0 x -1.0, four times -> -4.0, exactly representable
        base = vld_cnt;
        send_vec(16'h2000, 16'hE000);
        wait_vld(base + 1, "s2_timeout");
        check("s2_dot", {16'd0, got_dot[got_dot.size()-1]}, 32'h8000);
        check("s2_ovf", {31'd0, got_ovf[got_ovf.size()-1]}, 32'd0);

        // 1.0 x 1.0, four times -> +4.0, out of range
        base = vld_cnt;
        send_vec(16'h2000, 16'h2000);
        wait_vld(base + 1, "s3_timeout");
`ifdef DOT_SAT_EN
        check("s3_dot", {16'd0, got_dot[got_dot.size()-1]}, 32'h7FFF);
        check("s3_ovf", {31'd0, got_ovf[got_ovf.size()-1]}, 32'd1);
`else
        check("s3_dot", {16'd0, got_dot[got_dot.size()-1]}, 32'h8000);
        check("s3_ovf", {31'd0, got_ovf[got_ovf.size()-1]}, 32'd0);
`endif

        // I_VLD held high for 8 pairs k x 1.0 -> sums 10 and 26
        base = vld_cnt;
        hbase = hs_cnt;
        for (int k = 1; k <= 8; k++) send_pair(16'(k), 16'h2000, 1'b0);
        wait_vld(base + 2, "s4_timeout");
        check("s4_handshakes", hs_cnt - hbase, 8);
        check("s4_count", vld_cnt - base, 2);
        if (vld_cnt - base >= 2) begin
            check("s4_dot0", {16'd0, got_dot[base]}, 32'd10);
            check("s4_dot1", {16'd0, got_dot[base+1]}, 32'd26);
        end

        // reset one cycle after the 2nd product of a vector
        base = vld_cnt;
        mbase = mul_vld_cnt;
        fork
            begin
                for (int i = 0; i < VEC_LEN; i++) send_pair(16'h1000, 16'h1000, 1'b0);
            end
            begin
                n = 0;
                while (mul_vld_cnt < mbase + 2 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                if (mul_vld_cnt < mbase + 2) note_fail("s5_mul_timeout");
                @(negedge clk);
                abort = 1'b1;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        bus.I_VLD = 1'b0;
        check("s5_dot_cleared", {16'd0, bus.O_DOT}, 32'd0);
        repeat (40) @(negedge clk);
        check("s5_no_vld", vld_cnt - base, 0);
        send_vec(16'h1000, 16'h1000);
        wait_vld(base + 1, "s5_timeout");
        check("s5_count", vld_cnt - base, 1);
        check("s5_dot", {16'd0, got_dot[got_dot.size()-1]}, 32'h2000);

        // stray product with nothing in flight
        base = vld_cnt;
        repeat (10) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        send_vec(16'h1000, 16'h1000);
        wait_vld(base + 1, "s6_timeout");
        check("s6_count", vld_cnt - base, 1);
        check("s6_dot", {16'd0, got_dot[got_dot.size()-1]}, 32'h2000);

        // random vectors with idle gaps and ignored garbage while I_VLD=0
        base = vld_cnt;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_pair(16'($urandom), 16'($urandom), 1'b1);
            end
        end
        wait_vld(base + 8, "rand_timeout");
        check("rand_count", vld_cnt - base, 8);
        check("pending_results", exp_dot_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
